// File: rtl/regfile_ctl.sv
// ----------------------------------------------------------------------------
// regfile_ctl
//
// Clocked register file for the 16-bit datapath. It sits between instruction
// decode (which supplies addresses) and the ALU / writeback stage (which
// consumes read data and supplies write data).
//
// Features:
//   * two combinational read ports with write-to-read bypass
//   * one synchronous write port whose destination is rt or rd (reg_dst_i)
//   * optional hard-wired zero register 0 (ZERO_R0)
//   * a sequenced clear engine that zeroes one register per cycle
//   * a valid/ready debug dump port that streams every register in order
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   rs_addr_i      read port 1 address
//   rt_addr_i      read port 2 address, write destination when reg_dst_i=0
//   rd_addr_i      write destination when reg_dst_i=1
//   rs_data_o      read port 1 data (combinational, bypassed)
//   rt_data_o      read port 2 data (combinational, bypassed)
//   reg_dst_i      destination select: 0 -> rt_addr_i, 1 -> rd_addr_i
//   wr_en_i        write request
//   wr_data_i      write data
//   wr_drop_o      one-cycle pulse: last cycle's write was rejected (busy)
//   clr_req_i      start a sequential clear of all registers (IDLE only)
//   dump_req_i     start a register dump (IDLE only)
//   busy_o         clear or dump in progress
//   dump_valid_o   dump beat valid
//   dump_ready_i   consumer accepts the current dump beat
//   dump_idx_o     register index of the current dump beat
//   dump_data_o    contents of register dump_idx_o
// ----------------------------------------------------------------------------
module regfile_ctl #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_R0  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    input  logic              reg_dst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_drop_o,
    input  logic              clr_req_i,
    input  logic              dump_req_i,
    output logic              busy_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic              HAS_R0Z  = (ZERO_R0 != 0);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_drop_q;
    logic              wr_drop_d;

    // ------------------------------------------------------------------------
    // Write path decode
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] wa_s;       // selected write address
    logic              idle_s;     // FSM is in IDLE
    logic              wr_acc_s;   // write accepted this cycle
    logic              wr_upd_s;   // accepted write actually changes storage

    // Write address selection and acceptance; a write to the hard-wired zero
    // register is accepted (no drop pulse) but never stored.
    always_comb begin
        wa_s     = reg_dst_i ? rd_addr_i : rt_addr_i;
        idle_s   = (state_q == ST_IDLE);
        wr_acc_s = wr_en_i & idle_s;
        if (HAS_R0Z && (wa_s == ZERO_IDX)) begin
            wr_upd_s = 1'b0;
        end else begin
            wr_upd_s = wr_acc_s;
        end
    end

    // Returns the value a read port shows for address a: forced zero for the
    // hard-wired register, bypassed write data on an accepted write to the
    // same address, otherwise the stored contents.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic              acc,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        if (HAS_R0Z && (a == ZERO_IDX)) begin
            r = {DATA_W{1'b0}};
        end else if (acc && (wa == a)) begin
            r = wd;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Combinational read ports with write-to-read bypass.
    always_comb begin
        rs_data_o = read_port(rs_addr_i, wr_acc_s, wa_s, wr_data_i, regs_q[rs_addr_i]);
        rt_data_o = read_port(rt_addr_i, wr_acc_s, wa_s, wr_data_i, regs_q[rt_addr_i]);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // State and sequence counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Request arbitration (clear beats dump) and counter sequencing for the
    // clear and dump engines. Requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else if (dump_req_i) begin
                    state_d = ST_DUMP;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_CLEAR: begin
                // One register cleared per cycle; leave after the last one.
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DUMP: begin
                // Advance only on a handshake so idx/data hold while stalled.
                if (dump_ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        cnt_d   = {ADDR_W{1'b0}};
                    end else begin
                        state_d = ST_DUMP;
                        cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_DUMP;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // Status and dump beat outputs decoded from the registered state; the dump
    // fields read as zero whenever no dump is running.
    always_comb begin
        case (state_q)
            ST_IDLE: begin
                busy_o       = 1'b0;
                dump_valid_o = 1'b0;
                dump_idx_o   = {ADDR_W{1'b0}};
                dump_data_o  = {DATA_W{1'b0}};
            end
            ST_CLEAR: begin
                busy_o       = 1'b1;
                dump_valid_o = 1'b0;
                dump_idx_o   = {ADDR_W{1'b0}};
                dump_data_o  = {DATA_W{1'b0}};
            end
            ST_DUMP: begin
                busy_o       = 1'b1;
                dump_valid_o = 1'b1;
                dump_idx_o   = cnt_q;
                dump_data_o  = regs_q[cnt_q];
            end
            default: begin
                busy_o       = 1'b0;
                dump_valid_o = 1'b0;
                dump_idx_o   = {ADDR_W{1'b0}};
                dump_data_o  = {DATA_W{1'b0}};
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------------
    // Storage update: the clear engine owns the array while clearing; writes
    // can only land in IDLE, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (state_q == ST_CLEAR) begin
                regs_q[cnt_q] <= {DATA_W{1'b0}};
            end else if (wr_upd_s) begin
                regs_q[wa_s] <= wr_data_i;
            end else begin
                regs_q[cnt_q] <= regs_q[cnt_q];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Dropped-write indication
    // ------------------------------------------------------------------------
    // A write request seen while busy is rejected and flagged next cycle.
    always_comb begin
        wr_drop_d = wr_en_i & ~idle_s;
    end

    // Registered drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_regfile_ctl.sv
// ----------------------------------------------------------------------------
// tb_regfile_ctl
//
// Drives two regfile_ctl instances (ZERO_R0=0 and ZERO_R0=1) with identical
// stimulus. A behavioural model (plain arrays plus a mode/counter pair) gives
// the expected outputs of both; a compare process checks them on every
// falling edge. Directed sequences pin the model with literal expectations,
// followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_regfile_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rs_addr, rt_addr, rd_addr;
    logic        reg_dst, wr_en, clr_req, dump_req, dump_ready;
    logic [15:0] wr_data;

    logic [15:0] rs0, rt0, dd0, rs1, rt1, dd1;
    logic [3:0]  di0, di1;
    logic        drop0, busy0, dv0, drop1, busy1, dv1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_ctl #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .rs_data_o(rs0), .rt_data_o(rt0),
        .reg_dst_i(reg_dst), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_drop_o(drop0), .clr_req_i(clr_req), .dump_req_i(dump_req),
        .busy_o(busy0), .dump_valid_o(dv0), .dump_ready_i(dump_ready),
        .dump_idx_o(di0), .dump_data_o(dd0)
    );

    regfile_ctl #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .rs_data_o(rs1), .rt_data_o(rt1),
        .reg_dst_i(reg_dst), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_drop_o(drop1), .clr_req_i(clr_req), .dump_req_i(dump_req),
        .busy_o(busy1), .dump_valid_o(dv1), .dump_ready_i(dump_ready),
        .dump_idx_o(di1), .dump_data_o(dd1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 clearing, 2 dumping; cnt is the register being worked on
    int          m_mode = 0;
    int          m_cnt  = 0;
    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];
    logic        m_drop = 1'b0;

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_drop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
    endtask

    function automatic logic [15:0] exp_rd(input bit z, input logic [3:0] a);
        logic [3:0] wa;
        wa = reg_dst ? rd_addr : rt_addr;
        if (z && a == 4'd0) return 16'h0000;
        if (wr_en && m_mode == 0 && wa == a) return wr_data;
        return z ? mem1[a] : mem0[a];
    endfunction

    task automatic model_step();
        logic [3:0] wa;
        wa = reg_dst ? rd_addr : rt_addr;
        m_drop = wr_en && (m_mode != 0);
        case (m_mode)
            0: begin
                if (wr_en) begin
                    mem0[wa] = wr_data;
                    if (wa != 4'd0) mem1[wa] = wr_data;
                end
                if (clr_req) begin
                    m_mode = 1; m_cnt = 0;
                end else if (dump_req) begin
                    m_mode = 2; m_cnt = 0;
                end
            end
            1: begin
                mem0[m_cnt] = 16'h0000;
                mem1[m_cnt] = 16'h0000;
                if (m_cnt == 15) begin m_mode = 0; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end
            default: begin
                if (dump_ready) begin
                    if (m_cnt == 15) begin m_mode = 0; m_cnt = 0; end
                    else m_cnt = m_cnt + 1;
                end
            end
        endcase
    endtask

    // Compare process: check every falling edge, advance model on rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("rs0", rs0, exp_rd(1'b0, rs_addr));
            chk("rt0", rt0, exp_rd(1'b0, rt_addr));
            chk("rs1", rs1, exp_rd(1'b1, rs_addr));
            chk("rt1", rt1, exp_rd(1'b1, rt_addr));
            chk("busy0", busy0, m_mode != 0);
            chk("busy1", busy1, m_mode != 0);
            chk("dv0", dv0, m_mode == 2);
            chk("idx0", di0, (m_mode == 2) ? m_cnt : 0);
            chk("dd0", dd0, (m_mode == 2) ? mem0[m_cnt] : 16'h0000);
            chk("dd1", dd1, (m_mode == 2) ? mem1[m_cnt] : 16'h0000);
            chk("drop0", drop0, m_drop);
            chk("drop1", drop1, m_drop);
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        wr_en   = 1'b1;
        reg_dst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            wr_data = 16'(i) * 16'h0101;
            rs_addr = 4'($urandom_range(0, 15));
            step();
        end
        wr_en = 1'b0;
    endtask

    logic [3:0]  q_idx  [$];
    logic [15:0] q_data [$];
    int          busy_cnt;

    initial begin
        rst_n = 1'b0; rs_addr = 4'd0; rt_addr = 4'd0; rd_addr = 4'd0;
        reg_dst = 1'b0; wr_en = 1'b0; wr_data = 16'h0000;
        clr_req = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Reset state: all addresses read zero.
        for (int a = 0; a < 16; a++) begin
            rs_addr = 4'(a); rt_addr = 4'(15 - a);
            #1;
            chk("rst_rs", rs0, 32'h0);
            chk("rst_rt", rt0, 32'h0);
            step();
        end
        chk("rst_busy", busy0, 32'h0);
        chk("rst_dv", dv0, 32'h0);

        // Bypass through rd destination.
        wr_en = 1'b1; reg_dst = 1'b1; rd_addr = 4'd5; rt_addr = 4'd3;
        wr_data = 16'hBEEF; rs_addr = 4'd5;
        #1;
        chk("bypass_rs", rs0, 32'h0000BEEF);
        chk("bypass_rt_other", rt0, 32'h0);
        step();
        wr_en = 1'b0;
        #1;
        chk("after_wr_rs", rs0, 32'h0000BEEF);
        // rt destination writes reg 7 only.
        wr_en = 1'b1; reg_dst = 1'b0; rt_addr = 4'd7; rd_addr = 4'd9;
        wr_data = 16'h7777;
        step();
        wr_en = 1'b0; rs_addr = 4'd9; rt_addr = 4'd7;
        #1;
        chk("rt_dst_r7", rt0, 32'h00007777);
        chk("rt_dst_r9", rs0, 32'h0);

        // Zero register.
        wr_en = 1'b1; reg_dst = 1'b1; rd_addr = 4'd0; wr_data = 16'h1234;
        rs_addr = 4'd0;
        #1;
        chk("z_during", rs1, 32'h0);
        chk("nz_during", rs0, 32'h00001234);
        step();
        wr_en = 1'b0;
        #1;
        chk("z_after", rs1, 32'h0);
        chk("z_drop", drop1, 32'h0);

        // Clear sequence with a rejected write in the middle.
        fill();
        clr_req = 1'b1;
        step();
        clr_req  = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) begin
                wr_en = 1'b1; reg_dst = 1'b1; rd_addr = 4'd9; wr_data = 16'hFFFF;
            end else begin
                wr_en = 1'b0;
            end
            rs_addr = 4'(c);
            #2;
            if (c == 4) chk("clr_drop", drop0, 32'h1);
            if (!busy0) break;
            busy_cnt++;
            step();
        end
        chk("clr_busy_cycles", busy_cnt, 32'd16);
        rs_addr = 4'd9; rt_addr = 4'd15;
        #1;
        chk("clr_r9", rs0, 32'h0);
        chk("clr_r15", rt0, 32'h0);
        step();

        // Dump with stalling consumer and a mid-dump request.
        fill();
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        q_idx.delete(); q_data.delete();
        for (int c = 0; c < 100; c++) begin
            dump_ready = (c % 3 == 0);
            dump_req   = (c == 5);
            #2;
            if (!busy0) break;
            if (dv0 && dump_ready) begin
                q_idx.push_back(di0);
                q_data.push_back(dd0);
            end
            step();
        end
        dump_req = 1'b0;
        chk("dump_beats", q_idx.size(), 32'd16);
        for (int i = 0; i < 16 && i < q_idx.size(); i++) begin
            chk("dump_idx", q_idx[i], 32'(i));
            chk("dump_data", q_data[i], 32'(16'(i) * 16'h0101));
        end
        chk("dump_end_busy", busy0, 32'h0);
        step();

        // Reset in the middle of a dump.
        fill();
        dump_req = 1'b1; dump_ready = 1'b1;
        step();
        dump_req = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #2;
            if (di0 == 4'd6) break;
            step();
        end
        chk("pre_rst_idx", di0, 32'd6);
        rst_n = 1'b0; rs_addr = 4'd3;
        #1;
        chk("mid_rst_busy", busy0, 32'h0);
        chk("mid_rst_dv", dv0, 32'h0);
        chk("mid_rst_idx", di0, 32'h0);
        chk("mid_rst_data", dd0, 32'h0);
        chk("mid_rst_rs", rs0, 32'h0);
        step(); step();
        rst_n = 1'b1;
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        q_idx.delete(); q_data.delete();
        for (int c = 0; c < 40; c++) begin
            #2;
            if (!busy0) break;
            if (dv0) begin
                q_idx.push_back(di0);
                q_data.push_back(dd0);
            end
            step();
        end
        chk("rdump_beats", q_idx.size(), 32'd16);
        for (int i = 0; i < 16 && i < q_idx.size(); i++) begin
            chk("rdump_idx", q_idx[i], 32'(i));
            chk("rdump_data", q_data[i], 32'h0);
        end
        step();

        // Randomized phase.
        for (int c = 0; c < 1500; c++) begin
            rs_addr    = 4'($urandom_range(0, 15));
            rt_addr    = 4'($urandom_range(0, 15));
            rd_addr    = 4'($urandom_range(0, 15));
            reg_dst    = 1'($urandom_range(0, 1));
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_data    = 16'($urandom);
            clr_req    = ($urandom_range(0, 39) == 0);
            dump_req   = ($urandom_range(0, 24) == 0);
            dump_ready = ($urandom_range(0, 9) < 7);
            rst_n      = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
